cg_seq_proc: RTL and testbench
==============================

// Module: cg_seq_proc
// PURPOSE
//  Design-side counterpart of the CG lab stimulus interface. Captures a 6-word burst of
//  signed 9-bit samples plus a 3-bit mode, then processes it: optional negate, optional
//  sort, optional running sum. Streams 6 results back on out_valid/out_data.
//  Storage bank may be clock-gated under cg_en (see CONFIGURATION).
// PARAMETERS
//  DATA_W  9  sample width, two's complement
//  NUM     6  samples per burst; also the number of odd-even sort passes
//  MODE_W  3  mode width
// PORTS
//  clk        in   1       single clock; all flops on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  cg_en      in   1       clock-gating enable (used only with CG_GATE_EN)
//  in_valid   in   1       high for exactly NUM consecutive cycles per burst
//  in_data    in   DATA_W  sample, one per in_valid cycle
//  in_mode    in   MODE_W  valid only on the first in_valid cycle; X otherwise
//  out_valid  out  1       high for exactly NUM consecutive cycles per burst
//  out_data   out  DATA_W  result; must be 0 whenever out_valid=0
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, out_data=0, sample bank/accumulator/counters=0.
//    Reset takes effect immediately; a reset during LOAD/PROC/OUT aborts the burst,
//    and nothing is output for it.
//  - FSM: IDLE -> LOAD on the edge sampling in_valid=1 (word0 and mode latched there).
//    LOAD: 5 more words, counter 1..5; LOAD -> NEG after word5.
//    NEG (1 cycle): mode[0]=1 negates each word, saturating -256 -> +255.
//    SORT (NUM cycles): odd-even transposition pass per cycle, ascending signed.
//      Runs only if mode[1]=1; otherwise the bank holds. Cycle count fixed either way.
//    OUT (NUM cycles): emits bank[0..5] in order -> IDLE.
//  - Latency: last word sampled at edge T; out_valid=1 after edge T+8, low after T+14.
//    Independent of mode.
//  - mode[2]=1: out_data = saturated running sum. acc starts at 0;
//    acc = sat(acc+bank[k]) to [-256,255] each step, so saturation applies per step.
//    mode[2]=0: out_data = bank[k].
//  - Applied order is always negate -> sort -> sum.
//  - out_data registered; driven 0 on every cycle with out_valid=0.
//  - in_valid while not IDLE is ignored. The next burst arrives >=2 cycles after
//    out_valid falls.
//  - Comparisons and sums are signed; the adder is 10 bits wide before saturation.
// CONFIGURATION
//  CG_GATE_EN defined: a latch-based ICG drives the sample-bank/accumulator clock.
//    gate enable = (state!=IDLE) | in_valid | ~cg_en; with cg_en=1 the bank clock is
//    stopped in IDLE. FSM and output flops stay on ungated clk.
//  CG_GATE_EN undefined: no gating cell; cg_en is ignored.
//  Outputs must be cycle-identical in both builds for every cg_en value.
// TESTING
//  mode=000, data 1,2,3,4,5,6 -> out 1,2,3,4,5,6; out_valid exactly 6 cycles,
//    first at T+8.
//  mode=010, data 5,-3,0,255,-256,7 -> out -256,-3,0,5,7,255 (raw 256,509,0,5,7,255).
//  mode=001, data -256,255,0,-1,1,100 -> out 255,-255,0,1,-1,-100.
//  mode=100, data 200,100,-50,-256,10,0 -> out 200,255,205,-51,-41,-41.
//  mode=111, data 1,2,3,4,5,6 -> out -6,-11,-15,-18,-20,-21. Repeat with cg_en=0 and
//    cg_en=1, each under CG_GATE_EN on and off: results identical.
//  rst_n=0 during the 3rd OUT cycle -> out_valid=0 and out_data=0 immediately;
//    the next burst (mode=000, 9,8,7,6,5,4) -> out 9,8,7,6,5,4 with latency T+8.

Source files
------------

// File: rtl/cg_seq_proc.sv
// cg_seq_proc: captures a 6-word signed burst + mode, applies negate -> sort -> running sum, streams 6 results.
// Latency: last input word sampled at edge T, first out_valid after edge T+8, out_valid low after edge T+14.
// Backpressure: none; in_valid is ignored outside IDLE. Optional CG_GATE_EN build gates the bank/acc clock.
module cg_seq_proc #(
  parameter int DATA_W = 9,
  parameter int NUM    = 6,
  parameter int MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cg_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int CNT_W = $clog2(NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM - 1);
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, LOAD, NEG, SORT, OUT} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MODE_W-1:0]        mode_q, mode_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic signed [DATA_W-1:0] bank_q [NUM];
  logic signed [DATA_W-1:0] bank_d [NUM];
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] elem;
  logic signed [DATA_W:0]   sum_w;
  logic signed [DATA_W-1:0] sum_sat;
  logic                     bank_clk;

`ifdef CG_GATE_EN
  // Bank clock runs whenever a burst is in flight, a word is arriving, or gating is disabled.
  logic gate_en;
  logic gate_en_lat;
  assign gate_en = (state_q != IDLE) | in_valid | ~cg_en;

  // Latch enable while clk is low so the gated clock never glitches.
  always_latch begin
    if (!clk) gate_en_lat = gate_en;
  end

  assign bank_clk = clk & gate_en_lat;
`else
  // No gating cell in this build; cg_en has no effect.
  logic unused_cg_en;
  assign unused_cg_en = cg_en;
  assign bank_clk     = clk;
`endif

  // Element addressed by the OUT counter and its saturated running sum (10-bit add).
  always_comb begin
    elem = '0;
    for (int i = 0; i < NUM; i++) begin
      if (cnt_q == i[CNT_W-1:0]) elem = bank_q[i];
    end
    sum_w = {acc_q[DATA_W-1], acc_q} + {elem[DATA_W-1], elem};
    if (sum_w[DATA_W] != sum_w[DATA_W-1]) sum_sat = sum_w[DATA_W] ? S_MIN : S_MAX;
    else                                  sum_sat = sum_w[DATA_W-1:0];
  end

  // Next-state, datapath and output decode for the burst FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    for (int i = 0; i < NUM; i++) bank_d[i] = bank_q[i];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bank_d[0] = in_data;
          mode_d    = in_mode;
          cnt_d     = CNT_W'(1);
          state_d   = LOAD;
        end
      end
      LOAD: begin
        for (int i = 0; i < NUM; i++) begin
          if (cnt_q == i[CNT_W-1:0]) bank_d[i] = in_data;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = NEG;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      NEG: begin
        if (mode_q[0]) begin
          for (int i = 0; i < NUM; i++) begin
            bank_d[i] = (bank_q[i] == S_MIN) ? S_MAX : -bank_q[i];
          end
        end
        acc_d   = '0;
        cnt_d   = '0;
        state_d = SORT;
      end
      SORT: begin
        // Even passes compare (0,1),(2,3)..; odd passes (1,2),(3,4)..; pairs are disjoint.
        if (mode_q[1]) begin
          for (int i = 0; i < NUM - 1; i++) begin
            if ((i[0] == cnt_q[0]) && (bank_q[i] > bank_q[i+1])) begin
              bank_d[i]   = bank_q[i+1];
              bank_d[i+1] = bank_q[i];
            end
          end
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OUT: begin
        out_valid_d = 1'b1;
        acc_d       = sum_sat;
        out_data_d  = mode_q[2] ? sum_sat : elem;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers on the free-running clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Sample bank and accumulator on the (possibly gated) bank clock.
  always_ff @(posedge bank_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) bank_q[i] <= '0;
      acc_q <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) bank_q[i] <= bank_d[i];
      acc_q <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_cg_seq_proc.sv
// Directed bench for cg_seq_proc: per-mode bursts with hand-computed results,
// latency/framing checks, cg_en variations and an abort by reset during output.
module tb_cg_seq_proc;

  typedef logic [8:0] vec_t [6];

  logic       clk;
  logic       rst_n;
  logic       cg_en;
  logic       in_valid;
  logic [8:0] in_data;
  logic [2:0] in_mode;
  logic       out_valid;
  logic [8:0] out_data;

  int cmp_cnt = 0;
  int err_cnt = 0;

  cg_seq_proc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cg_en    (cg_en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive six words on consecutive cycles; returns right after edge T (at its following negedge).
  task automatic drive_burst(input logic [2:0] mode, input vec_t din);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = din[i];
      in_mode  = (i == 0) ? mode : 3'bxxx;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = 3'bxxx;
  endtask

  // Full burst: checks quiet output T+1..T+7, six words T+8..T+13, quiet again at T+14.
  task automatic run_burst(input string name, input logic [2:0] mode, input vec_t din, input vec_t exp);
    drive_burst(mode, din);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      cmp_cnt++;
      if (out_valid !== 1'b0 || out_data !== 9'd0) begin
        err_cnt++;
        $display("FAIL %s early T+%0d: got valid=%b data=%h, want valid=0 data=000", name, k, out_valid, out_data);
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cmp_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp[k]) begin
        err_cnt++;
        $display("FAIL %s word%0d: got valid=%b data=%0d (%h), want valid=1 data=%0d (%h)",
                 name, k, out_valid, $signed(out_data), out_data, $signed(exp[k]), exp[k]);
      end
    end
    @(negedge clk);
    cmp_cnt++;
    if (out_valid !== 1'b0 || out_data !== 9'd0) begin
      err_cnt++;
      $display("FAIL %s tail: got valid=%b data=%h, want valid=0 data=000", name, out_valid, out_data);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    cg_en    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = '0;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (out_valid !== 1'b0 || out_data !== 9'd0) begin
      err_cnt++;
      $display("FAIL reset_state: got valid=%b data=%h, want valid=0 data=000", out_valid, out_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if (out_valid !== 1'b0 || out_data !== 9'd0) begin
      err_cnt++;
      $display("FAIL post_reset_idle: got valid=%b data=%h, want valid=0 data=000", out_valid, out_data);
    end
  endtask

  task automatic test_pass_through;
    run_burst("mode000", 3'b000, '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6}, '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6});
  endtask

  task automatic test_sort;
    run_burst("mode010", 3'b010, '{9'd5, -9'sd3, 9'd0, 9'd255, -9'sd256, 9'd7},
              '{9'h100, 9'h1FD, 9'd0, 9'd5, 9'd7, 9'd255});
  endtask

  task automatic test_negate;
    run_burst("mode001", 3'b001, '{-9'sd256, 9'd255, 9'd0, -9'sd1, 9'd1, 9'd100},
              '{9'd255, -9'sd255, 9'd0, 9'd1, -9'sd1, -9'sd100});
  endtask

  task automatic test_sum;
    run_burst("mode100", 3'b100, '{9'd200, 9'd100, -9'sd50, -9'sd256, 9'd10, 9'd0},
              '{9'd200, 9'd255, 9'd205, -9'sd51, -9'sd41, -9'sd41});
  endtask

  task automatic test_all_modes_cg;
    cg_en = 1'b0;
    run_burst("mode111_cg0", 3'b111, '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6},
              '{-9'sd6, -9'sd11, -9'sd15, -9'sd18, -9'sd20, -9'sd21});
    cg_en = 1'b1;
    repeat (5) @(negedge clk);
    run_burst("mode111_cg1", 3'b111, '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6},
              '{-9'sd6, -9'sd11, -9'sd15, -9'sd18, -9'sd20, -9'sd21});
  endtask

  task automatic test_back_to_back;
    run_burst("b2b_a", 3'b010, '{9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1}, '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6});
    run_burst("b2b_b", 3'b000, '{9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1}, '{9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1});
  endtask

  task automatic test_reset_mid_out;
    drive_burst(3'b000, '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6});
    // Now just after edge T; the third output word is shown after edge T+10.
    repeat (10) @(negedge clk);
    cmp_cnt++;
    if (out_valid !== 1'b1 || out_data !== 9'd3) begin
      err_cnt++;
      $display("FAIL abort_pre: got valid=%b data=%0d, want valid=1 data=3", out_valid, out_data);
    end
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (out_valid !== 1'b0 || out_data !== 9'd0) begin
      err_cnt++;
      $display("FAIL abort_immediate: got valid=%b data=%h, want valid=0 data=000", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cmp_cnt++;
      if (out_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL abort_quiet cyc%0d: got valid=%b, want 0", k, out_valid);
      end
    end
    run_burst("after_abort", 3'b000, '{9'd9, 9'd8, 9'd7, 9'd6, 9'd5, 9'd4}, '{9'd9, 9'd8, 9'd7, 9'd6, 9'd5, 9'd4});
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_sort();
    test_negate();
    test_sum();
    test_all_modes_cg();
    test_back_to_back();
    test_reset_mid_out();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
